// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: one req/ack bus transaction per lw/st command.
// Optional REQ timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_master #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      cmd_inM,
   input  logic [AW-1:0]   addrM,
   input  logic [DW-1:0]   wdataM,
   input  logic [DW/8-1:0] beM,
   output logic            stall_out,
   output logic            ack_out,
   output logic            done_out,
   output logic [DW-1:0]   rdataW,
   output logic            err_out,
   output logic            bus_req,
   output logic            bus_we,
   output logic [AW-1:0]   bus_addr,
   output logic [DW-1:0]   bus_wdata,
   output logic [DW/8-1:0] bus_be,
   input  logic            bus_ack,
   input  logic [DW-1:0]   bus_rdata
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e state;
   logic   mem_cmd;
   logic   unused_addr;

   assign mem_cmd     = cmd_inM[1];
   assign unused_addr = ^addrM[1:0];

`ifdef LSU_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       timed_out;

   assign timed_out = (wait_cnt == 8'(TIMEOUT));
`else
   assign err_out = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
         rdataW    <= '0;
`ifdef LSU_TIMEOUT_EN
         err_out   <= 1'b0;
         wait_cnt  <= 8'd0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (mem_cmd) begin
                  state     <= StReq;
                  bus_req   <= 1'b1;
                  bus_we    <= (cmd_inM == 2'b10);
                  bus_addr  <= {addrM[AW-1:2], 2'b00};
                  bus_wdata <= wdataM;
                  bus_be    <= beM;
`ifdef LSU_TIMEOUT_EN
                  wait_cnt  <= 8'd0;
`endif
               end
            end
            StReq: begin
               // A same-cycle ack wins over the timeout.
               if (bus_ack) begin
                  state   <= StDone;
                  bus_req <= 1'b0;
                  if (!bus_we) rdataW <= bus_rdata;
`ifdef LSU_TIMEOUT_EN
                  err_out <= 1'b0;
               end else if (timed_out) begin
                  state   <= StDone;
                  bus_req <= 1'b0;
                  err_out <= 1'b1;
                  rdataW  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
`endif
               end
            end
            StDone: begin
               // Command still present here belongs to the finished access.
               state <= StIdle;
`ifdef LSU_TIMEOUT_EN
               err_out <= 1'b0;
`endif
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign stall_out = ((state == StIdle) && mem_cmd) || (state == StReq);
   assign ack_out   = (state != StReq);
   assign done_out  = (state == StDone);

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: transaction-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_lsu_bus_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    cmd;
   logic [31:0]   addr, wdata, rdataW, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]    be, bus_be;
   logic          stall_out, ack_out, done_out, err_out, bus_req, bus_we, bus_ack;

   lsu_bus_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .cmd_inM(cmd), .addrM(addr), .wdataM(wdata), .beM(be),
      .stall_out(stall_out), .ack_out(ack_out), .done_out(done_out), .rdataW(rdataW),
      .err_out(err_out), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit run = 1'b0;
   int req_cycles, req_starts, done_pulses;
   logic prev_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      req_cycles = 0;
      req_starts = 0;
      done_pulses = 0;
   endtask

   // Transaction model: an access is either open on the bus or finishing this cycle.
   bit          m_open, m_fin, m_we, m_err;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   int          m_waited;

   always @(posedge clk) begin
      if (reset) begin
         m_open = 0; m_fin = 0; m_we = 0; m_err = 0;
         m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0; m_waited = 0;
      end else if (m_fin) begin
         m_fin = 0;
      end else if (m_open) begin
         if (bus_ack) begin
            if (!m_we) m_rdata = bus_rdata;
            m_open = 0; m_fin = 1; m_err = 0;
         end else if (TimeoutEn && m_waited == TO) begin
            m_open = 0; m_fin = 1; m_err = 1; m_rdata = 0;
         end else begin
            m_waited++;
         end
      end else if (cmd[1]) begin
         m_open = 1; m_waited = 0;
         m_we = (cmd == 2'b10);
         m_addr = addr & 32'hFFFF_FFFC;
         m_wdata = wdata;
         m_be = be;
      end
   end

   always @(negedge clk) begin
      if (run) begin
         chk("req", bus_req, m_open);
         chk("stall", stall_out, m_open || (!m_open && !m_fin && cmd[1]));
         chk("ack", ack_out, !m_open);
         chk("done", done_out, m_fin);
         chk("addr", bus_addr, m_addr);
         chk("we", bus_we, m_we);
         chk("wdata", bus_wdata, m_wdata);
         chk("be", bus_be, m_be);
         chk("rdata", rdataW, m_rdata);
         if (m_fin) chk("err", err_out, m_err);
         if (!TimeoutEn) chk("err_tied", err_out, 0);
      end
      if (bus_req) req_cycles++;
      if (bus_req && !prev_req) req_starts++;
      if (done_out) done_pulses++;
      prev_req = bus_req;
   end

   initial begin
      reset = 1; cmd = 0; addr = 0; wdata = 0; be = 0; bus_ack = 0; bus_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      run = 1;
      #2;
      chk("rst_ack", ack_out, 1);
      chk("rst_req", bus_req, 0);
      chk("rst_done", done_out, 0);
      chk("rst_rdata", rdataW, 0);
      chk("rst_addr", bus_addr, 0);

      // 1: lw 0x104, zero-wait ack
      cmd = 2'b11; addr = 32'h104;
      #2 chk("t1_stall_c1", stall_out, 1);
      step(); bus_ack = 1; bus_rdata = 32'hDEADBEEF;
      #2 chk("t1_stall_c2", stall_out, 1);
      chk("t1_addr", bus_addr, 32'h104);
      step(); bus_ack = 0; cmd = 2'b00;
      #2 chk("t1_stall_c3", stall_out, 0);
      chk("t1_done", done_out, 1);
      chk("t1_rdata", rdataW, 32'hDEADBEEF);
      step();

      // 2: st 0x0F3 with 4 wait cycles
      clear_counts();
      cmd = 2'b10; addr = 32'h0F3; wdata = 32'h12345678; be = 4'h3;
      step(); cmd = 2'b00; addr = 32'h555; wdata = 0; be = 0;
      #2 chk("t2_addr", bus_addr, 32'h0F0);
      chk("t2_we", bus_we, 1);
      chk("t2_be", bus_be, 4'h3);
      repeat (4) step();
      bus_ack = 1;
      step(); bus_ack = 0;
      step();
      chk("t2_req_cycles", req_cycles, 5);
      chk("t2_done_pulses", done_pulses, 1);
      chk("t2_rdata_kept", rdataW, 32'hDEADBEEF);

      // 3: back-to-back lw then st, command changes on the DONE edge
      clear_counts();
      cmd = 2'b11; addr = 32'h200;
      step(); bus_ack = 1; bus_rdata = 32'hAAAA5555;
      step(); bus_ack = 0;
      step(); cmd = 2'b10; addr = 32'h208; wdata = 32'hCAFEF00D; be = 4'hF;
      step(); bus_ack = 1; bus_rdata = 32'h11111111;
      step(); bus_ack = 0; cmd = 2'b00;
      step(); step();
      chk("t3_req_starts", req_starts, 2);
      chk("t3_done_pulses", done_pulses, 2);
      chk("t3_rdata", rdataW, 32'hAAAA5555);

`ifdef LSU_TIMEOUT_EN
      // 6: lw with no ack, TIMEOUT=4
      clear_counts();
      cmd = 2'b11; addr = 32'h400;
      step(); cmd = 2'b00;
      repeat (4) step();
      step();
      #2 chk("t6_done", done_out, 1);
      chk("t6_err", err_out, 1);
      chk("t6_rdata", rdataW, 0);
      step();
      chk("t6_req_cycles", req_cycles, 5);
`endif

      // 4: reset during the second REQ cycle, ack arrives the cycle after
      clear_counts();
      cmd = 2'b11; addr = 32'h300;
      step(); cmd = 2'b00;
      step(); reset = 1;
      step(); reset = 0; bus_ack = 1; bus_rdata = 32'h0BADF00D;
      #2 chk("t4_req", bus_req, 0);
      chk("t4_done", done_out, 0);
      chk("t4_ack", ack_out, 1);
      step(); bus_ack = 0;
      step();
      chk("t4_done_pulses", done_pulses, 0);
      chk("t4_rdata", rdataW, 0);

      // 5: jmp/other commands with spurious acks
      clear_counts();
      for (int i = 0; i < 10; i++) begin
         cmd = (i % 2 == 1) ? 2'b01 : 2'b00;
         bus_ack = (i % 3 == 0);
         bus_rdata = 32'h1000 + i;
         step();
      end
      bus_ack = 0; cmd = 2'b00;
      step();
      chk("t5_req_starts", req_starts, 0);
      chk("t5_done_pulses", done_pulses, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
